// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared types and defaults for the jump charge controller
package jump_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    CHARGE,
    LAUNCH,
    AIRBORNE
  } state_t;

  localparam int TICK_DIV_DEF   = 500_000;
  localparam int CHARGE_MAX_DEF = 31;

  // Exactly one of left/right pressed gives that direction; both or neither give NONE.
  function automatic dir_t resolve_dir(input logic left, input logic right);
    if (left && !right) begin
      return LEFT;
    end else if (right && !left) begin
      return RIGHT;
    end else begin
      return NONE;
    end
  endfunction

endpackage

// File: rtl/charge_timer.sv
// rtl/charge_timer.sv - tick prescaler feeding a saturating charge counter
module charge_timer #(
  parameter int TICK_DIV   = 4,
  parameter int CHARGE_MAX = 7,
  parameter int CHARGE_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  output logic [CHARGE_W-1:0] level,
  output logic                saturated,
  output logic                saturating
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]       TICK_ONE  = TW'(1);
  localparam logic [CHARGE_W-1:0] LVL_MAX   = CHARGE_W'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] LVL_PRE   = CHARGE_W'(CHARGE_MAX - 1);
  localparam logic [CHARGE_W-1:0] LVL_ONE   = CHARGE_W'(1);

  logic [TW-1:0] tick;
  logic          wrap;

  assign wrap       = enable && (tick == TICK_LAST);
  assign saturated  = (level == LVL_MAX);
  // High on the enabled edge that will carry the level up to its maximum.
  assign saturating = wrap && (level == LVL_PRE);

  // Prescaler wraps every TICK_DIV enabled cycles and bumps the level until it saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick  <= '0;
      level <= '0;
    end else if (clear) begin
      tick  <= '0;
      level <= '0;
    end else if (enable) begin
      if (wrap) begin
        tick <= '0;
        if (!saturated) begin
          level <= level + LVL_ONE;
        end
      end else begin
        tick <= tick + TICK_ONE;
      end
    end
  end

endmodule

// File: rtl/jump_charge_ctl.sv
// rtl/jump_charge_ctl.sv - key-level to handshaked jump command sequencer
module jump_charge_ctl
  import jump_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int CHARGE_MAX = CHARGE_MAX_DEF,
  parameter int CHARGE_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_space,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                on_ground,
  output logic                jump_valid,
  input  logic                jump_ready,
  output logic [CHARGE_W-1:0] jump_power,
  output logic [1:0]          jump_dir,
  output logic [1:0]          walk_dir,
  output logic                charging,
  output logic [CHARGE_W-1:0] charge_level
);

  localparam logic [CHARGE_W-1:0] POWER_MIN = CHARGE_W'(1);
  localparam logic [CHARGE_W-1:0] POWER_MAX = CHARGE_W'(CHARGE_MAX);

  state_t state;
  logic   seen_air;
  logic   armed;
  dir_t   key_dir;
  logic   handshake;
  logic   timer_clear;
  logic   timer_enable;
  logic   level_sat;
  logic   level_saturating;
  logic   charge_full;

  assign key_dir     = resolve_dir(key_left, key_right);
  assign handshake   = (state == LAUNCH) && jump_ready;
  assign charge_full = level_saturating || level_sat;

  // The timer only runs while the charge is actually continuing, so a release
  // edge freezes the level that was latched as power.
  assign timer_enable = (state == CHARGE) && on_ground && key_space;
  assign timer_clear  = ((state == IDLE) && on_ground && key_space && armed)
                     || ((state == CHARGE) && !on_ground)
                     || handshake;

  charge_timer #(
    .TICK_DIV   (TICK_DIV),
    .CHARGE_MAX (CHARGE_MAX),
    .CHARGE_W   (CHARGE_W)
  ) u_charge_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear),
    .enable     (timer_enable),
    .level      (charge_level),
    .saturated  (level_sat),
    .saturating (level_saturating)
  );

  // Jump state machine with registered command, walk and charging outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AIRBORNE;
      seen_air   <= 1'b1;
      armed      <= 1'b0;
      jump_valid <= 1'b0;
      jump_power <= '0;
      jump_dir   <= NONE;
      walk_dir   <= NONE;
      charging   <= 1'b0;
    end else begin
      if (!key_space) begin
        armed <= 1'b1;
      end
      if (!on_ground && (state != LAUNCH)) begin
        seen_air <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!on_ground) begin
            state    <= AIRBORNE;
            walk_dir <= NONE;
          end else if (key_space && armed) begin
            state    <= CHARGE;
            charging <= 1'b1;
            walk_dir <= NONE;
          end else begin
            walk_dir <= key_dir;
          end
        end
        CHARGE: begin
          if (!on_ground) begin
            state    <= AIRBORNE;
            charging <= 1'b0;
          end else if (!key_space || charge_full) begin
            state      <= LAUNCH;
            charging   <= 1'b0;
            jump_valid <= 1'b1;
            jump_dir   <= key_dir;
            armed      <= 1'b0;
            if (!key_space) begin
              jump_power <= (charge_level == '0) ? POWER_MIN : charge_level;
            end else begin
              jump_power <= POWER_MAX;
            end
          end
        end
        LAUNCH: begin
          if (jump_ready) begin
            state      <= AIRBORNE;
            jump_valid <= 1'b0;
            seen_air   <= 1'b0;
          end
        end
        AIRBORNE: begin
          if (on_ground && seen_air) begin
            state    <= IDLE;
            walk_dir <= key_dir;
          end
        end
        default: begin
          state <= AIRBORNE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jump_charge_ctl.sv
// tb/tb_jump_charge_ctl.sv - self-checking bench for jump_charge_ctl
module tb_jump_charge_ctl;

  localparam int TD = 4;
  localparam int CM = 7;
  localparam int CW = 5;

  localparam int S_IDLE = 0;
  localparam int S_CHG  = 1;
  localparam int S_LAU  = 2;
  localparam int S_AIR  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_space, key_left, key_right, on_ground, jump_ready;
  logic          jump_valid, charging;
  logic [CW-1:0] jump_power, charge_level;
  logic [1:0]    jump_dir, walk_dir;

  int n_tests = 0;
  int n_fail  = 0;

  int m_st, m_k, m_power, m_dir, m_walk;
  bit m_seen, m_armed, m_valid, m_charging;

  typedef struct {
    bit space, left, right, ground, ready;
    bit exp_valid;
    int exp_walk;
    bit exp_charging;
    int exp_level;
    int exp_power;
    int exp_dir;
  } vec_t;

  vec_t vecs[9];

  jump_charge_ctl #(.TICK_DIV(TD), .CHARGE_MAX(CM), .CHARGE_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_space    (key_space),
    .key_left     (key_left),
    .key_right    (key_right),
    .on_ground    (on_ground),
    .jump_valid   (jump_valid),
    .jump_ready   (jump_ready),
    .jump_power   (jump_power),
    .jump_dir     (jump_dir),
    .walk_dir     (walk_dir),
    .charging     (charging),
    .charge_level (charge_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int res_dir(input bit l, input bit r);
    if (l && !r) return 1;
    if (r && !l) return 2;
    return 0;
  endfunction

  // Charge earned after k cycles spent charging.
  function automatic int chg(input int k);
    int c;
    c = k / TD;
    return (c > CM) ? CM : c;
  endfunction

  task automatic model_reset();
    m_st = S_AIR; m_seen = 1; m_armed = 0; m_k = 0;
    m_valid = 0; m_power = 0; m_dir = 0; m_walk = 0; m_charging = 0;
  endtask

  task automatic model_step();
    int  nst;
    bit  launch;
    int  pw;
    int  d;
    nst = m_st; launch = 0; pw = 0;
    d = res_dir(key_left, key_right);
    case (m_st)
      S_IDLE: begin
        if (!on_ground) nst = S_AIR;
        else if (key_space && m_armed) begin nst = S_CHG; m_k = 0; end
      end
      S_CHG: begin
        if (!on_ground) begin nst = S_AIR; m_k = 0; end
        else if (!key_space) begin launch = 1; pw = (chg(m_k) < 1) ? 1 : chg(m_k); end
        else if (chg(m_k + 1) >= CM) begin launch = 1; pw = CM; m_k++; end
        else m_k++;
      end
      S_LAU: begin
        if (jump_ready) begin nst = S_AIR; m_seen = 0; m_k = 0; end
      end
      default: begin
        if (on_ground && m_seen) nst = S_IDLE;
      end
    endcase
    if (!on_ground && m_st != S_LAU) m_seen = 1;
    if (launch) begin
      nst = S_LAU; m_power = pw; m_dir = d; m_armed = 0;
    end else if (!key_space) begin
      m_armed = 1;
    end
    m_st       = nst;
    m_walk     = (nst == S_IDLE) ? d : 0;
    m_valid    = (nst == S_LAU);
    m_charging = (nst == S_CHG);
  endtask

  task automatic compare_model();
    chk("model_valid", jump_valid, m_valid);
    chk("model_walk", walk_dir, m_walk);
    chk("model_charging", charging, m_charging);
    chk("model_level", charge_level, chg(m_k));
    if (m_valid) begin
      chk("model_power", jump_power, m_power);
      chk("model_jdir", jump_dir, m_dir);
    end
  endtask

  task automatic cycle(input bit s, input bit l, input bit r, input bit g, input bit rdy);
    key_space = s; key_left = l; key_right = r; on_ground = g; jump_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic land();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    int launch_at, pw, held;
    bit rs, rg;

    vecs[0] = '{0,0,0,1,0, 0,0,0,0,0,0};
    vecs[1] = '{0,1,0,1,0, 0,1,0,0,0,0};
    vecs[2] = '{0,1,1,1,0, 0,0,0,0,0,0};
    vecs[3] = '{0,0,1,1,0, 0,2,0,0,0,0};
    vecs[4] = '{1,0,1,1,0, 0,0,1,0,0,0};
    vecs[5] = '{0,0,1,1,0, 1,0,0,0,1,2};
    vecs[6] = '{0,0,0,1,1, 0,0,0,0,0,0};
    vecs[7] = '{0,0,0,0,0, 0,0,0,0,0,0};
    vecs[8] = '{0,1,0,1,0, 0,1,0,0,0,0};

    rst = 1; key_space = 0; key_left = 0; key_right = 0; on_ground = 1; jump_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", jump_valid, 0);
    chk("reset_power", jump_power, 0);
    chk("reset_jdir", jump_dir, 0);
    chk("reset_walk", walk_dir, 0);
    chk("reset_charging", charging, 0);
    chk("reset_level", charge_level, 0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].space, vecs[i].left, vecs[i].right, vecs[i].ground, vecs[i].ready);
      chk("vec_valid", jump_valid, vecs[i].exp_valid);
      chk("vec_walk", walk_dir, vecs[i].exp_walk);
      chk("vec_charging", charging, vecs[i].exp_charging);
      chk("vec_level", charge_level, vecs[i].exp_level);
      if (vecs[i].exp_valid) begin
        chk("vec_power", jump_power, vecs[i].exp_power);
        chk("vec_jdir", jump_dir, vecs[i].exp_dir);
      end
    end

    // Hold space 13 cycles, release with right and ready high.
    repeat (13) cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 1);
    chk("hold13_valid", jump_valid, 1);
    chk("hold13_power", jump_power, 3);
    chk("hold13_dir", jump_dir, 2);
    cycle(0, 0, 0, 1, 1);
    chk("hold13_one_cycle", jump_valid, 0);
    land();

    // Ready held low while keys and ground toggle: payload must stay put.
    repeat (9) cycle(1, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    held = jump_valid ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
      chk("stall_valid", jump_valid, 1);
      chk("stall_power", jump_power, 2);
      chk("stall_dir", jump_dir, 1);
      if (jump_valid) held++;
    end
    cycle(0, 0, 0, 1, 1);
    chk("stall_accept", jump_valid, 0);
    chk("stall_held_cycles", held, 11);
    land();

    // Auto-launch at saturation, then space kept down through a landing.
    cycle(1, 0, 0, 1, 1);
    launch_at = -1; pw = -1;
    for (int i = 1; i < 40; i++) begin
      cycle(1, 0, 0, 1, 1);
      if (jump_valid && launch_at < 0) begin
        launch_at = i; pw = jump_power;
      end
    end
    chk("auto_launch_cycle", launch_at, CM * TD);
    chk("auto_launch_power", pw, CM);
    repeat (2) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1, 0);
      chk("held_no_recharge", charging, 0);
    end
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    chk("repress_charges", charging, 1);
    cycle(0, 0, 0, 1, 1);
    chk("repress_tap_power", jump_power, 1);
    cycle(0, 0, 0, 1, 1);
    land();

    // Ground lost mid-charge aborts without a command.
    repeat (6) cycle(1, 0, 0, 1, 0);
    chk("abort_pre_level", charge_level, 1);
    cycle(1, 0, 0, 0, 0);
    chk("abort_level", charge_level, 0);
    chk("abort_valid", jump_valid, 0);
    chk("abort_charging", charging, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);

    // Asynchronous reset while a command is pending.
    repeat (3) cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    chk("pre_rst_valid", jump_valid, 1);
    #3;
    rst = 1;
    #1;
    chk("async_rst_valid", jump_valid, 0);
    chk("async_rst_power", jump_power, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    // Randomised traffic against the reference model.
    rs = 0; rg = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rs = ~rs;
      if ($urandom_range(0, 9) == 0) rg = ~rg;
      if (!rg && $urandom_range(0, 2) == 0) rg = 1;
      cycle(rs, $urandom_range(0, 1), $urandom_range(0, 1), rg, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
